// File: rtl/weight_fetch_if.sv
// weight_fetch_if: job control, ROM read port and packed beat stream of the weight fetch unit
interface weight_fetch_if #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int LANES      = 4,
  parameter int LEN_WIDTH  = 16
);
  logic                       start;
  logic [ADDR_WIDTH-1:0]      base_addr;
  logic [LEN_WIDTH-1:0]       length;
  logic                       busy;
  logic                       done;
  logic                       rom_en;
  logic [ADDR_WIDTH-1:0]      rom_addr;
  logic [DATA_SIZE-1:0]       rom_data;
  logic [LANES*DATA_SIZE-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  modport master (
    input  start, base_addr, length, rom_data, out_ready,
    output busy, done, rom_en, rom_addr, out_data, out_valid, out_last
  );
  modport slave (
    output start, base_addr, length, rom_data, out_ready,
    input  busy, done, rom_en, rom_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/weight_fetch_unit.sv
// weight_fetch_unit: streams a run of ROM words through a credit-limited return FIFO into packed multi-lane beats
module weight_fetch_unit #(
  parameter int DATA_SIZE   = 8,
  parameter int ADDR_WIDTH  = 20,
  parameter int LANES       = 4,
  parameter int ROM_LATENCY = 1,
  parameter int LEN_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input logic clk,
  input logic rst_n,
  weight_fetch_if.master bus
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = LANES * DATA_SIZE;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  next_addr, iss_addr;
  logic [LEN_WIDTH-1:0]   rd_left, pk_left;
  logic [ROM_LATENCY-1:0] pipe;
  logic [DATA_SIZE-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          cnt, used;
  logic [LW-1:0]          lc;
  logic [BW-1:0]          acc, beat;
  logic [DATA_SIZE-1:0]   word;
  logic                   issue, push, pop, avail, bypass, fin, hs, last_word;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  // used counts every word issued but not yet packed, so FIFO room is reserved at issue time
  always_comb begin
    push      = pipe[ROM_LATENCY-1];
    avail     = cnt != '0 || push;
    word      = cnt != '0 ? mem[rd_ptr] : bus.rom_data;
    last_word = pk_left == LEN_WIDTH'(1);
    fin       = lc == LW'(LANES - 1) || last_word;
    hs        = bus.out_valid && bus.out_ready;
    pop       = avail && (!fin || !bus.out_valid || bus.out_ready);
    bypass    = push && pop && cnt == '0;
    iss_addr  = state == IDLE ? bus.base_addr : next_addr;
    issue     = state == IDLE ? bus.start && bus.length != '0
              : state == FETCH && rd_left != '0 && (used - CW'(pop)) < CW'(FIFO_DEPTH);
    beat      = acc;
    beat[lc*DATA_SIZE +: DATA_SIZE] = word;
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = !bus.start ? IDLE : bus.length == '0 ? DONE : FETCH;
      FETCH:   state_nxt = rd_left == '0 || (issue && rd_left == LEN_WIDTH'(1)) ? DRAIN : FETCH;
      DRAIN:   state_nxt = hs && bus.out_last ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pipe          <= '0;
      bus.rom_en    <= 1'b0;
      bus.rom_addr  <= '0;
      next_addr     <= '0;
      rd_left       <= '0;
      pk_left       <= '0;
      used          <= '0;
      cnt           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      lc            <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pipe       <= (pipe << 1) | ROM_LATENCY'(bus.rom_en);
      bus.rom_en <= issue;
      if (issue) begin
        bus.rom_addr <= iss_addr;
        next_addr    <= iss_addr + 1'b1;
        rd_left      <= (state == IDLE ? bus.length : rd_left) - 1'b1;
      end
      if (state == IDLE && bus.start) pk_left <= bus.length;
      else if (pop) pk_left <= pk_left - 1'b1;
      used <= used + CW'(issue) - CW'(pop);
      cnt  <= cnt + CW'(push) - CW'(pop);
      if (push && !bypass) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop && cnt != '0) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      if (hs) bus.out_valid <= 1'b0;
      if (pop && fin) begin
        bus.out_data  <= beat;
        bus.out_valid <= 1'b1;
        bus.out_last  <= last_word;
        acc           <= '0;
        lc            <= '0;
      end else if (pop) begin
        acc <= beat;
        lc  <= lc + 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (push && !bypass) mem[wr_ptr] <= bus.rom_data;
endmodule
